pipe_stage_elastic: RTL and testbench

- Parametrised, elastic successor to the fixed stage-boundary registers (D/E, E/M, M/W).
- Carries one instruction bundle across a pipeline boundary using a valid/ready handshake, optionally with a 2-entry skid buffer.
- Each entry keeps a saturating T_new countdown and a registered-value "ready for forwarding" flag.
- Supports stall via backpressure and flush via bubble insertion, so one module can replace every inter-stage register.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_entry.sv | 47 ++++
 rtl/pipe_stage_elastic.sv | 114 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: T_new and register-index widths, stage constants,
// write-back select encoding and the saturating T_new decrement.
package pipe_pkg;

  localparam int PIPE_TNEW_W = 2;
  localparam int PIPE_A3_W   = 5;

  localparam logic [PIPE_TNEW_W-1:0] TNEW_ZERO = '0;
  localparam logic [PIPE_TNEW_W-1:0] TNEW_E    = 2'd2;
  localparam logic [PIPE_TNEW_W-1:0] TNEW_M    = 2'd1;

  // Write-back source select carried opaquely inside the payload.
  typedef enum logic [1:0] {
    SELW_ALU = 2'd0,
    SELW_DM  = 2'd1,
    SELW_PC8 = 2'd2
  } selw_e;

  // Saturating decrement; callers zero-extend into and truncate out of 32 bits.
  function automatic logic [31:0] tnew_dec(input logic [31:0] x);
    return (x == 32'd0) ? 32'd0 : x - 32'd1;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One held pipeline bundle: valid, destination, regwrite, T_new and payload.
// Clear beats load; a held entry's T_new counts down every clock.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 128,
  parameter int A3_W      = PIPE_A3_W,
  parameter int TNEW_W    = PIPE_TNEW_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] ld_payload,
  input  logic [A3_W-1:0]      ld_a3,
  input  logic                 ld_regwrite,
  input  logic [TNEW_W-1:0]    ld_tnew,
  output logic                 valid,
  output logic [PAYLOAD_W-1:0] payload,
  output logic [A3_W-1:0]      a3,
  output logic                 regwrite,
  output logic [TNEW_W-1:0]    tnew
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  // NOTE: the payload register is reset as well, so an empty entry always reads
  // as all-zero and the output gating stays trivially correct.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid    <= 1'b0;
      payload  <= '0;
      a3       <= '0;
      regwrite <= 1'b0;
      tnew     <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      payload  <= ld_payload;
      a3       <= ld_a3;
      regwrite <= ld_regwrite;
      tnew     <= TNEW_W'(tnew_dec(32'(ld_tnew)));
    end else begin
      tnew     <= TNEW_W'(tnew_dec(32'(tnew)));
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline boundary register with optional 2-entry skid buffer,
// T_new countdown, forwarding-ready flag, backpressure stall and flush.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 128,
  parameter int A3_W      = PIPE_A3_W,
  parameter int TNEW_W    = PIPE_TNEW_W,
  parameter bit SKID_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [A3_W-1:0]      in_a3,
  input  logic                 in_regwrite,
  input  logic [TNEW_W-1:0]    in_tnew,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [A3_W-1:0]      out_a3,
  output logic                 out_regwrite,
  output logic [TNEW_W-1:0]    out_tnew,
  output logic                 fwd_ok,
  output logic [1:0]           occupancy
);

  logic                 head_valid, skid_valid;
  logic [PAYLOAD_W-1:0] head_payload, skid_payload;
  logic [A3_W-1:0]      head_a3, skid_a3;
  logic                 head_regwrite, skid_regwrite;
  logic [TNEW_W-1:0]    head_tnew, skid_tnew;

  logic accept, pop, from_skid;
  logic head_load, head_clear;

  // Flush discards the presented bundle even when in_ready is high.
  assign accept = in_valid & in_ready & ~flush;
  assign pop    = head_valid & out_ready;

  generate
    if (SKID_EN) begin : g_skid
      logic skid_load, skid_clear;

      assign in_ready   = ~skid_valid;
      assign from_skid  = pop & skid_valid;
      assign head_load  = from_skid | (accept & (~head_valid | pop));
      assign head_clear = flush | (pop & ~head_load);
      assign skid_load  = accept & head_valid & ~pop;
      assign skid_clear = flush | from_skid;

      pipe_entry #(
        .PAYLOAD_W (PAYLOAD_W),
        .A3_W      (A3_W),
        .TNEW_W    (TNEW_W)
      ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .clear       (skid_clear),
        .load        (skid_load),
        .ld_payload  (in_payload),
        .ld_a3       (in_a3),
        .ld_regwrite (in_regwrite),
        .ld_tnew     (in_tnew),
        .valid       (skid_valid),
        .payload     (skid_payload),
        .a3          (skid_a3),
        .regwrite    (skid_regwrite),
        .tnew        (skid_tnew)
      );
    end else begin : g_single
      assign in_ready      = ~head_valid | out_ready;
      assign from_skid     = 1'b0;
      assign head_load     = accept;
      assign head_clear    = flush | (pop & ~accept);
      assign skid_valid    = 1'b0;
      assign skid_payload  = '0;
      assign skid_a3       = '0;
      assign skid_regwrite = 1'b0;
      assign skid_tnew     = '0;
    end
  endgenerate

  pipe_entry #(
    .PAYLOAD_W (PAYLOAD_W),
    .A3_W      (A3_W),
    .TNEW_W    (TNEW_W)
  ) u_head (
    .clk         (clk),
    .reset       (reset),
    .clear       (head_clear),
    .load        (head_load),
    .ld_payload  (from_skid ? skid_payload  : in_payload),
    .ld_a3       (from_skid ? skid_a3       : in_a3),
    .ld_regwrite (from_skid ? skid_regwrite : in_regwrite),
    .ld_tnew     (from_skid ? skid_tnew     : in_tnew),
    .valid       (head_valid),
    .payload     (head_payload),
    .a3          (head_a3),
    .regwrite    (head_regwrite),
    .tnew        (head_tnew)
  );

  assign out_valid    = head_valid;
  assign out_payload  = head_valid ? head_payload : '0;
  assign out_a3       = head_valid ? head_a3      : '0;
  assign out_regwrite = head_valid & head_regwrite;
  assign out_tnew     = head_valid ? head_tnew    : '0;
  assign fwd_ok       = out_valid & out_regwrite & (out_a3 != '0) & (out_tnew == TNEW_W'(0));
  assign occupancy    = {1'b0, head_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench: table-driven vectors on the skid-buffer stage plus hand-written
// reset and single-entry replace sequences.
module tb_pipe_stage_elastic;

  localparam int PW = 128;
  localparam int AW = 5;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_regwrite, out_ready;
  logic [PW-1:0] in_payload;
  logic [AW-1:0] in_a3;
  logic [TW-1:0] in_tnew;

  logic          s_in_ready, s_out_valid, s_out_regwrite, s_fwd_ok;
  logic [PW-1:0] s_out_payload;
  logic [AW-1:0] s_out_a3;
  logic [TW-1:0] s_out_tnew;
  logic [1:0]    s_occupancy;

  logic          u_in_ready, u_out_valid, u_out_regwrite, u_fwd_ok;
  logic [PW-1:0] u_out_payload;
  logic [AW-1:0] u_out_a3;
  logic [TW-1:0] u_out_tnew;
  logic [1:0]    u_occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.PAYLOAD_W(PW), .A3_W(AW), .TNEW_W(TW), .SKID_EN(1'b1)) dut_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_payload(in_payload),
    .in_a3(in_a3), .in_regwrite(in_regwrite), .in_tnew(in_tnew),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_payload(s_out_payload),
    .out_a3(s_out_a3), .out_regwrite(s_out_regwrite), .out_tnew(s_out_tnew),
    .fwd_ok(s_fwd_ok), .occupancy(s_occupancy)
  );

  pipe_stage_elastic #(.PAYLOAD_W(PW), .A3_W(AW), .TNEW_W(TW), .SKID_EN(1'b0)) dut_single (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(u_in_ready), .in_payload(in_payload),
    .in_a3(in_a3), .in_regwrite(in_regwrite), .in_tnew(in_tnew),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_payload(u_out_payload),
    .out_a3(u_out_a3), .out_regwrite(u_out_regwrite), .out_tnew(u_out_tnew),
    .fwd_ok(u_fwd_ok), .occupancy(u_occupancy)
  );

  typedef struct {
    logic          fl, iv, rw, ordy;
    logic [AW-1:0] a3;
    logic [TW-1:0] tn;
    logic [PW-1:0] pl;
    logic          e_ov, e_rw, e_fwd, e_ir;
    logic [AW-1:0] e_a3;
    logic [TW-1:0] e_tn;
    logic [1:0]    e_occ;
    logic [PW-1:0] e_pl;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(
    input logic fl, input logic iv, input logic [AW-1:0] a3, input logic rw,
    input logic [TW-1:0] tn, input logic [PW-1:0] pl, input logic ordy,
    input logic e_ov, input logic [AW-1:0] e_a3, input logic e_rw,
    input logic [TW-1:0] e_tn, input logic e_fwd, input logic [1:0] e_occ,
    input logic e_ir, input logic [PW-1:0] e_pl);
    vec_t v;
    v.fl = fl; v.iv = iv; v.a3 = a3; v.rw = rw; v.tn = tn; v.pl = pl; v.ordy = ordy;
    v.e_ov = e_ov; v.e_a3 = e_a3; v.e_rw = e_rw; v.e_tn = e_tn; v.e_fwd = e_fwd;
    v.e_occ = e_occ; v.e_ir = e_ir; v.e_pl = e_pl;
    return v;
  endfunction

  task automatic check(input string name, input logic [PW-1:0] actual, input logic [PW-1:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [AW-1:0] a3, input logic rw,
                       input logic [TW-1:0] tn, input logic [PW-1:0] pl, input logic ordy);
    @(negedge clk);
    flush = fl; in_valid = iv; in_a3 = a3; in_regwrite = rw;
    in_tnew = tn; in_payload = pl; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          fl iv a3  rw tn pl        ordy | ov a3 rw tn fwd occ ir pl
    vecs[0]  = mk(0, 1, 5,  1, 2, 128'hA5, 1,   1, 5,  1, 1, 0, 1, 1, 128'hA5);
    vecs[1]  = mk(0, 1, 6,  1, 2, 128'hA6, 1,   1, 6,  1, 1, 0, 1, 1, 128'hA6);
    vecs[2]  = mk(0, 1, 7,  1, 2, 128'hA7, 1,   1, 7,  1, 1, 0, 1, 1, 128'hA7);
    vecs[3]  = mk(0, 0, 0,  0, 0, 128'h0,  0,   1, 7,  1, 0, 1, 1, 1, 128'hA7);
    vecs[4]  = mk(0, 0, 0,  0, 0, 128'h0,  1,   0, 0,  0, 0, 0, 0, 1, 128'h0);
    vecs[5]  = mk(0, 1, 8,  1, 3, 128'hB8, 0,   1, 8,  1, 2, 0, 1, 1, 128'hB8);
    vecs[6]  = mk(0, 1, 9,  1, 1, 128'hB9, 0,   1, 8,  1, 1, 0, 2, 0, 128'hB8);
    vecs[7]  = mk(0, 1, 10, 1, 3, 128'hBA, 0,   1, 8,  1, 0, 1, 2, 0, 128'hB8);
    vecs[8]  = mk(0, 0, 0,  0, 0, 128'h0,  1,   1, 9,  1, 0, 1, 1, 1, 128'hB9);
    vecs[9]  = mk(0, 0, 0,  0, 0, 128'h0,  1,   0, 0,  0, 0, 0, 0, 1, 128'h0);
    vecs[10] = mk(0, 1, 11, 1, 2, 128'hC1, 0,   1, 11, 1, 1, 0, 1, 1, 128'hC1);
    vecs[11] = mk(0, 1, 12, 1, 2, 128'hC2, 0,   1, 11, 1, 0, 1, 2, 0, 128'hC1);
    vecs[12] = mk(1, 1, 13, 1, 2, 128'hC3, 0,   0, 0,  0, 0, 0, 0, 1, 128'h0);
    vecs[13] = mk(1, 1, 14, 1, 2, 128'hC4, 1,   0, 0,  0, 0, 0, 0, 1, 128'h0);
    vecs[14] = mk(0, 0, 0,  0, 0, 128'h0,  1,   0, 0,  0, 0, 0, 0, 1, 128'h0);
    vecs[15] = mk(0, 1, 0,  1, 0, 128'hD0, 0,   1, 0,  1, 0, 0, 1, 1, 128'hD0);
    vecs[16] = mk(0, 0, 0,  0, 0, 128'h0,  1,   0, 0,  0, 0, 0, 0, 1, 128'h0);
    vecs[17] = mk(0, 1, 3,  1, 0, 128'hD3, 1,   1, 3,  1, 0, 1, 1, 1, 128'hD3);
    vecs[18] = mk(0, 1, 4,  0, 0, 128'hD4, 1,   1, 4,  0, 0, 0, 1, 1, 128'hD4);
    vecs[19] = mk(0, 0, 0,  0, 0, 128'h0,  1,   0, 0,  0, 0, 0, 0, 1, 128'h0);

    // Reset held with a valid bundle presented: nothing may be captured.
    drive(1'b0, 1'b1, 5'd9, 1'b1, 2'd3, 128'hFF, 1'b0);
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst.out_valid", PW'(s_out_valid), PW'(0));
    check("rst.occupancy", PW'(s_occupancy), PW'(0));
    check("rst.out_payload", s_out_payload, PW'(0));
    check("rst.out_a3", PW'(s_out_a3), PW'(0));
    check("rst.fwd_ok", PW'(s_fwd_ok), PW'(0));
    check("rst.single_valid", PW'(u_out_valid), PW'(0));
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst.in_ready", PW'(s_in_ready), PW'(1));
    check("rst.still_empty", PW'(s_out_valid), PW'(0));

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].a3, vecs[i].rw, vecs[i].tn, vecs[i].pl, vecs[i].ordy);
      check($sformatf("v%0d.out_valid", i), PW'(s_out_valid), PW'(vecs[i].e_ov));
      check($sformatf("v%0d.out_a3", i), PW'(s_out_a3), PW'(vecs[i].e_a3));
      check($sformatf("v%0d.out_regwrite", i), PW'(s_out_regwrite), PW'(vecs[i].e_rw));
      check($sformatf("v%0d.out_tnew", i), PW'(s_out_tnew), PW'(vecs[i].e_tn));
      check($sformatf("v%0d.fwd_ok", i), PW'(s_fwd_ok), PW'(vecs[i].e_fwd));
      check($sformatf("v%0d.occupancy", i), PW'(s_occupancy), PW'(vecs[i].e_occ));
      check($sformatf("v%0d.in_ready", i), PW'(s_in_ready), PW'(vecs[i].e_ir));
      check($sformatf("v%0d.out_payload", i), s_out_payload, vecs[i].e_pl);
    end

    // Single-entry stage: stall, then same-cycle pop and accept replaces head.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 5'd5, 1'b1, 2'd2, 128'hE5, 1'b0);
    check("se.load_valid", PW'(u_out_valid), PW'(1));
    check("se.load_a3", PW'(u_out_a3), PW'(5));
    check("se.load_tnew", PW'(u_out_tnew), PW'(1));
    check("se.stall_in_ready", PW'(u_in_ready), PW'(0));
    check("se.occ_max1", PW'(u_occupancy), PW'(1));
    drive(1'b0, 1'b1, 5'd6, 1'b1, 2'd2, 128'hE6, 1'b0);
    check("se.stall_a3", PW'(u_out_a3), PW'(5));
    check("se.stall_tnew", PW'(u_out_tnew), PW'(0));
    check("se.stall_fwd", PW'(u_fwd_ok), PW'(1));
    drive(1'b0, 1'b1, 5'd7, 1'b1, 2'd2, 128'hE7, 1'b1);
    check("se.replace_a3", PW'(u_out_a3), PW'(7));
    check("se.replace_payload", u_out_payload, 128'hE7);
    check("se.replace_tnew", PW'(u_out_tnew), PW'(1));
    check("se.replace_occ", PW'(u_occupancy), PW'(1));
    check("se.replace_in_ready", PW'(u_in_ready), PW'(1));
    drive(1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 128'h0, 1'b1);
    check("se.drain_valid", PW'(u_out_valid), PW'(0));
    check("se.drain_occ", PW'(u_occupancy), PW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_regwrite = 1'b0;
    out_ready = 1'b0; in_payload = '0; in_a3 = '0; in_tnew = '0;
  end

endmodule
